// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter that funnels cache-line requests onto one SDRAM controller.
// At most one controller transaction is outstanding; each port latches one pending request.
module sdram_arbiter #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_we,
   input  logic              a_start,
   output logic              a_done,
   output logic [DATA_W-1:0] a_q,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_we,
   input  logic              b_start,
   output logic              b_done,
   output logic [DATA_W-1:0] b_q,
   output logic [ADDR_W-1:0] sdc_addr,
   output logic [DATA_W-1:0] sdc_data,
   output logic              sdc_we,
   output logic              sdc_start,
   input  logic              sdc_done,
   input  logic [DATA_W-1:0] sdc_q
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state, state_nxt;
   logic              pend_a, pend_b;
   logic [ADDR_W-1:0] req_a_addr, req_b_addr;
   logic [DATA_W-1:0] req_a_data, req_b_data;
   logic              req_a_we, req_b_we;
   logic              grant;       // 1 = port B owns the in-flight transaction
   logic              last_grant;  // 1 = port B completed most recently
   logic              sel_b;
   logic              launch;
   logic              finish;

   // On a tie the port that did not complete last wins.
   assign sel_b  = pend_b & (~pend_a | ~last_grant);
   assign launch = (state == IDLE) & (pend_a | pend_b);
   assign finish = (state == WAIT) & sdc_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_a     <= 1'b0;
         req_a_addr <= '0;
         req_a_data <= '0;
         req_a_we   <= 1'b0;
      end else if (a_start && !pend_a) begin
         pend_a     <= 1'b1;
         req_a_addr <= a_addr;
         req_a_data <= a_data;
         req_a_we   <= a_we;
      end else if (finish && !grant) begin
         pend_a     <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_b     <= 1'b0;
         req_b_addr <= '0;
         req_b_data <= '0;
         req_b_we   <= 1'b0;
      end else if (b_start && !pend_b) begin
         pend_b     <= 1'b1;
         req_b_addr <= b_addr;
         req_b_data <= b_data;
         req_b_we   <= b_we;
      end else if (finish && grant) begin
         pend_b     <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pend_a || pend_b) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (sdc_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sdc_start = (state == ISSUE);
   end

   // Controller-side request is loaded once per grant and held through WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant      <= 1'b0;
         last_grant <= 1'b1;
         sdc_addr   <= '0;
         sdc_data   <= '0;
         sdc_we     <= 1'b0;
         a_done     <= 1'b0;
         b_done     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
      end else begin
         a_done <= 1'b0;
         b_done <= 1'b0;
         if (launch) begin
            grant    <= sel_b;
            sdc_addr <= sel_b ? req_b_addr : req_a_addr;
            sdc_data <= sel_b ? req_b_data : req_a_data;
            sdc_we   <= sel_b ? req_b_we   : req_a_we;
         end
         if (finish) begin
            last_grant <= grant;
            if (grant) begin
               b_q    <= sdc_q;
               b_done <= 1'b1;
            end else begin
               a_q    <= sdc_q;
               a_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; the bench itself plays the SDRAM controller.
module tb_sdram_arbiter;
   localparam int AW = 21;
   localparam int DW = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;
   logic          a_we, b_we, a_start, b_start;
   logic          a_done, b_done;
   logic [DW-1:0] a_q, b_q;
   logic [AW-1:0] sdc_addr;
   logic [DW-1:0] sdc_data;
   logic          sdc_we, sdc_start, sdc_done;
   logic [DW-1:0] sdc_q;

   int total = 0;
   int bad   = 0;

   localparam logic [DW-1:0] V1_DATA =
      256'hDEADBEEF_CAFEBABE_00112233_44556677_8899AABB_CCDDEEFF_11223344_DDEEFF00;
   localparam logic [DW-1:0] Q_RD  = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_F0F0_5555_AAAA_1357_9BDF_2468_ACE0;
   localparam logic [DW-1:0] Q_ALT = 256'hA5A5_5A5A_0000_FFFF_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;

   sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .a_addr(a_addr), .a_data(a_data), .a_we(a_we), .a_start(a_start),
      .a_done(a_done), .a_q(a_q),
      .b_addr(b_addr), .b_data(b_data), .b_we(b_we), .b_start(b_start),
      .b_done(b_done), .b_q(b_q),
      .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we),
      .sdc_start(sdc_start), .sdc_done(sdc_done), .sdc_q(sdc_q)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for sdc_start and checks the presented request.
   task automatic wait_issue(input string tag, input logic [AW-1:0] ea, input logic ewe,
                             input logic [DW-1:0] ed, output int n);
      n = 0;
      while (!sdc_start && n < 8) begin
         tick();
         n++;
      end
      check($sformatf("%s_start", tag), DW'(sdc_start), DW'(1'b1));
      check($sformatf("%s_addr", tag), DW'(sdc_addr), DW'(ea));
      check($sformatf("%s_we", tag), DW'(sdc_we), DW'(ewe));
      check($sformatf("%s_data", tag), sdc_data, ed);
   endtask

   // From the ISSUE cycle: enter WAIT, return sdc_done with q, land on the done cycle.
   task automatic finish_txn(input string tag, input logic [AW-1:0] ea, input logic [DW-1:0] q);
      tick();
      check($sformatf("%s_onecyc", tag), DW'(sdc_start), DW'(1'b0));
      check($sformatf("%s_hold", tag), DW'(sdc_addr), DW'(ea));
      sdc_done = 1'b1;
      sdc_q    = q;
      tick();
      sdc_done = 1'b0;
   endtask

   task automatic req_a(input logic [AW-1:0] ad, input logic we, input logic [DW-1:0] d);
      a_addr = ad; a_we = we; a_data = d; a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      a_addr = '0; a_data = '0; a_we = 1'b0; a_start = 1'b0;
      b_addr = '0; b_data = '0; b_we = 1'b0; b_start = 1'b0;
      sdc_done = 1'b0; sdc_q = '0;
      #2;
      check("rst_start", DW'(sdc_start), '0);
      check("rst_addr", DW'(sdc_addr), '0);
      check("rst_done", DW'({a_done, b_done}), '0);
      check("rst_aq", a_q, '0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // V1: write, two-cycle latency
      req_a(21'd16, 1'b1, V1_DATA);
      check("v1_nostart_early", DW'(sdc_start), '0);
      wait_issue("v1", 21'd16, 1'b1, V1_DATA, n);
      check("v1_latency", DW'(n), DW'(1));
      finish_txn("v1", 21'd16, '0);
      check("v1_adone", DW'(a_done), DW'(1'b1));
      tick();
      check("v1_adone_pulse", DW'(a_done), '0);

      // V2: read returns controller data to A only
      req_a(21'd16, 1'b0, '0);
      wait_issue("v2", 21'd16, 1'b0, '0, n);
      finish_txn("v2", 21'd16, Q_RD);
      check("v2_adone", DW'(a_done), DW'(1'b1));
      check("v2_aq", a_q, Q_RD);
      check("v2_bdone", DW'(b_done), '0);
      check("v2_bq", b_q, '0);
      tick();
      check("v2_aq_hold", a_q, Q_RD);

      // V3: simultaneous starts after reset -> A then B
      reset = 1'b1; tick(); reset = 1'b0; tick();
      a_addr = 21'd1; a_we = 1'b0; b_addr = 21'd2; b_we = 1'b0;
      a_start = 1'b1; b_start = 1'b1;
      tick();
      a_start = 1'b0; b_start = 1'b0;
      wait_issue("v3a", 21'd1, 1'b0, '0, n);
      finish_txn("v3a", 21'd1, Q_ALT);
      check("v3a_done", DW'({a_done, b_done}), DW'(2'b10));
      wait_issue("v3b", 21'd2, 1'b0, '0, n);
      check("v3b_latency", DW'(n), DW'(1));
      finish_txn("v3b", 21'd2, Q_RD);
      check("v3b_done", DW'({a_done, b_done}), DW'(2'b01));
      check("v3b_q", b_q, Q_RD);
      check("v3b_aq_keep", a_q, Q_ALT);
      tick();
      a_start = 1'b1; b_start = 1'b1;
      tick();
      a_start = 1'b0; b_start = 1'b0;
      wait_issue("v3a2", 21'd1, 1'b0, '0, n);
      finish_txn("v3a2", 21'd1, '0);
      wait_issue("v3b2", 21'd2, 1'b0, '0, n);
      finish_txn("v3b2", 21'd2, '0);
      // Both ports re-strobe during every WAIT, so B stays pending.
      a_start = 1'b1; b_start = 1'b1;
      tick();
      a_start = 1'b0; b_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [AW-1:0] ea;
         ea = (i % 2 == 0) ? 21'd1 : 21'd2;
         wait_issue($sformatf("v3rr%0d", i), ea, 1'b0, '0, n);
         tick();
         a_start = 1'b1; b_start = 1'b1;
         tick();
         a_start = 1'b0; b_start = 1'b0;
         sdc_done = 1'b1; sdc_q = DW'(i + 100);
         tick();
         sdc_done = 1'b0;
         check($sformatf("v3rr%0d_done", i), DW'({a_done, b_done}),
               (i % 2 == 0) ? DW'(2'b10) : DW'(2'b01));
      end
      wait_issue("v3drain", 21'd1, 1'b0, '0, n);
      finish_txn("v3drain", 21'd1, '0);
      tick();

      // V4: second b_start during WAIT ignored
      req_a(21'd5, 1'b0, '0);
      wait_issue("v4a", 21'd5, 1'b0, '0, n);
      tick();
      b_addr = 21'd7; b_we = 1'b1; b_data = V1_DATA; b_start = 1'b1;
      tick();
      b_addr = 21'd9; b_we = 1'b0; b_data = Q_RD;
      tick();
      b_start = 1'b0;
      sdc_done = 1'b1; sdc_q = Q_ALT;
      tick();
      sdc_done = 1'b0;
      check("v4_adone", DW'(a_done), DW'(1'b1));
      wait_issue("v4b", 21'd7, 1'b1, V1_DATA, n);
      check("v4b_latency", DW'(n), DW'(1));
      finish_txn("v4b", 21'd7, '0);
      check("v4b_done", DW'(b_done), DW'(1'b1));
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("v4_single%0d", i), DW'(sdc_start), '0);
      end

      // V5: reset during WAIT abandons the transaction
      req_a(21'd11, 1'b1, Q_RD);
      wait_issue("v5", 21'd11, 1'b1, Q_RD, n);
      tick();
      reset = 1'b1;
      #1;
      check("v5_rst_addr", DW'(sdc_addr), '0);
      check("v5_rst_data", sdc_data, '0);
      check("v5_rst_we", DW'(sdc_we), '0);
      check("v5_rst_q", DW'({a_q, b_q}), '0);
      tick();
      reset = 1'b0;
      sdc_done = 1'b1; sdc_q = Q_ALT;
      tick();
      sdc_done = 1'b0;
      check("v5_no_adone", DW'({a_done, b_done}), '0);
      check("v5_aq", a_q, '0);
      tick();
      check("v5_idle", DW'(sdc_start), '0);
      req_a(21'd12, 1'b0, '0);
      wait_issue("v5post", 21'd12, 1'b0, '0, n);
      check("v5post_latency", DW'(n), DW'(1));
      finish_txn("v5post", 21'd12, Q_ALT);
      check("v5post_done", DW'(a_done), DW'(1'b1));
      check("v5post_q", a_q, Q_ALT);

      // V6: new a_start in the a_done cycle
      a_addr = 21'd33; a_we = 1'b0; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("v6_adone_gone", DW'(a_done), '0);
      wait_issue("v6", 21'd33, 1'b0, '0, n);
      check("v6_latency", DW'(n), DW'(1));
      finish_txn("v6", 21'd33, Q_RD);
      check("v6_done", DW'(a_done), DW'(1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
